// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-select stage: select codes, flag bundle
// layout and the width of the stored {data, z, n, sel} word.
package alu_pkg;

  localparam int ALU_SEL_W = 2;

  localparam logic [ALU_SEL_W-1:0] CTRL_COMPARE  = 2'd0;
  localparam logic [ALU_SEL_W-1:0] CTRL_ANDORNOT = 2'd1;
  localparam logic [ALU_SEL_W-1:0] CTRL_ADDSUB   = 2'd2;

  typedef struct packed {
    logic z;
    logic n;
    logic sel;
  } alu_flags_t;

  localparam int FLAG_W = $bits(alu_flags_t);

  function automatic int bundle_w(input int width);
    return width + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready buffer: a main register driving the outputs plus one skid
// entry, so in_ready is a plain register with no path from out_ready.
module alu_skid_buf #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] r_main_data;
  logic          r_main_valid;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_valid;
  logic          w_accept;

  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign out_data  = r_main_data;
  assign out_valid = r_main_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      // Both entries full: no accept possible, only the skid->main refill.
      if (out_ready) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || out_ready) begin
        r_main_data  <= in_data;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_data  <= in_data;
        r_skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      r_main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_sel.sv
// ALU output-stage result selector: picks one unit result by ctrl, derives the
// z/n/illegal-select flags, counts illegal selects and hands off via a skid buffer.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int ERR_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         ctrl,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         s,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int BW = bundle_w(WIDTH);

  logic [WIDTH-1:0] w_src [NUM_SRC];
  logic [WIDTH-1:0] w_sel_data;
  logic             w_legal;
  alu_flags_t       w_flags;
  logic [BW-1:0]    w_in_bundle;
  logic [BW-1:0]    w_out_bundle;
  logic [ERR_W-1:0] r_err_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_legal = ({1'b0, ctrl} < (SEL_W+1)'(NUM_SRC));

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_legal && ctrl == SEL_W'(i)) begin
        w_sel_data = w_src[i];
      end
    end
  end

  always_comb begin
    w_flags     = '0;
    w_flags.z   = (w_sel_data == '0);
    w_flags.n   = w_sel_data[WIDTH-1];
    w_flags.sel = ~w_legal;
  end

  assign w_in_bundle = {w_sel_data, w_flags};

  alu_skid_buf #(
    .DW(BW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (w_in_bundle),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_out_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {s, flag_z, flag_n, flag_sel} = w_out_bundle;

  // Only accepted words count; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (in_valid && in_ready && !w_legal && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;

endmodule
